// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op encodings, counter width,
// default cycle counts, FSM states and the start-class decode helper.
// MDU_MADD_EN makes madd/maddu/msub/msubu start-class ops.
package mdu_defs;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;
   localparam logic [3:0] MD_MADD  = 4'd9;
   localparam logic [3:0] MD_MADDU = 4'd10;
   localparam logic [3:0] MD_MSUB  = 4'd11;
   localparam logic [3:0] MD_MSUBU = 4'd12;

   localparam int MDU_CNT_W    = 4;
   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

   typedef enum logic {IDLE, RUN} mdu_state_t;

   // Ops that occupy the unit for a multi-cycle run.
   function automatic logic is_start(input logic [3:0] op);
      logic s;
      s = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
      s = s || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
      return s;
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result for the multiply/divide/accumulate ops.
// Division by zero yields {A, all-ones}; 0x80000000 / -1 yields {0, 0x80000000}.
// Accumulate forms use the supplied hi/lo as the base; gating happens in the controller.
module mdu_calc
   import mdu_defs::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] res
);

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic [63:0]        acc;

   assign sa     = a;
   assign sb     = b;
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign q_s    = sa / sb;
   assign r_s    = sa % sb;
   assign acc    = {hi, lo};

   // Select the result for the presented op; corner cases of division override the divider.
   always_comb begin
      res = '0;
      case (op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV: begin
            if (b == 32'd0)
               res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               res = {32'd0, 32'h8000_0000};
            else
               res = {r_s, q_s};
         end
         MD_DIVU: begin
            if (b == 32'd0)
               res = {a, 32'hFFFF_FFFF};
            else
               res = {a % b, a / b};
         end
         MD_MADD:  res = acc + prod_s;
         MD_MADDU: res = acc + prod_u;
         MD_MSUB:  res = acc - prod_s;
         MD_MSUBU: res = acc - prod_u;
         default:  res = '0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller owning HI/LO; result lands MULT_CYC/DIV_CYC cycles after start.
// stall holds the pipe while busy or when a start-class op is presented; in-flight ops ignore cancel.
// Build with MDU_MADD_EN to enable madd/maddu/msub/msubu (otherwise codes 9-12 act as none).
module mdu_ctrl
   import mdu_defs::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rd
);

   localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYC);
   localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYC);

   mdu_state_t           state;
   logic [MDU_CNT_W-1:0] cnt;
   logic [31:0]          pend_hi;
   logic [31:0]          pend_lo;
   logic [63:0]          calc_res;
   logic                 start;
   logic                 is_div;
   logic                 hilo_op;

   assign start   = is_start(md_op);
   assign is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign hilo_op = (md_op == MD_MTHI) || (md_op == MD_MTLO) ||
                    (md_op == MD_MFHI) || (md_op == MD_MFLO);

   mdu_calc u_calc (
      .op  (md_op),
      .a   (A),
      .b   (B),
      .hi  (hi),
      .lo  (lo),
      .res (calc_res)
   );

   // Start-class ops always stall their own issue cycle; HI/LO accessors wait out a run.
   always_comb begin
      stall = busy || start || (hilo_op && busy);
   end

   // Move-from reads are combinational from the architectural HI/LO.
   always_comb begin
      md_rd = '0;
      if (md_op == MD_MFHI)
         md_rd = hi;
      else if (md_op == MD_MFLO)
         md_rd = lo;
   end

   // FSM: latch result at start, count down the run, commit HI/LO on the last cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!cancel) begin
                  if (start) begin
                     pend_hi <= calc_res[63:32];
                     pend_lo <= calc_res[31:0];
                     cnt     <= is_div ? DIV_CNT : MULT_CNT;
                     busy    <= 1'b1;
                     state   <= RUN;
                  end else if (md_op == MD_MTHI) begin
                     hi <= A;
                  end else if (md_op == MD_MTLO) begin
                     lo <= A;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == MDU_CNT_W'(1)) begin
                  hi    <= pend_hi;
                  lo    <= pend_lo;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic model of HI/LO, latency and stall.
module tb_mdu_ctrl;

   localparam int NM = 5;
   localparam int ND = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_rd;

   int checks = 0;
   int errors = 0;

   // model of architectural HI/LO
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_ctrl #(.MULT_CYC(NM), .DIV_CYC(ND)) dut (
      .clk    (clk),
      .reset  (reset),
      .md_op  (md_op),
      .A      (A),
      .B      (B),
      .cancel (cancel),
      .busy   (busy),
      .stall  (stall),
      .hi     (hi),
      .lo     (lo),
      .md_rd  (md_rd)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef MDU_MADD_EN
   localparam bit MADD_ON = 1'b1;
`else
   localparam bit MADD_ON = 1'b0;
`endif

   function automatic bit model_start(input logic [3:0] op);
      return (op >= 1 && op <= 4) || (MADD_ON && op >= 9 && op <= 12);
   endfunction

   function automatic int model_lat(input logic [3:0] op);
      return (op == 3 || op == 4) ? ND : NM;
   endfunction

   // Plain-arithmetic reference of the 64-bit {hi,lo} outcome.
   function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] base);
      longint sp, q, r;
      logic [63:0] up;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = 64'(a) * 64'(b);
      case (op)
         1: return sp;
         2: return up;
         3: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) - q * longint'($signed(b));
            return {r[31:0], q[31:0]};
         end
         4: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
         9:  return base + sp;
         10: return base + up;
         11: return base - sp;
         12: return base - up;
         default: return base;
      endcase
   endfunction

   // Presents a start op for one cycle then counts busy cycles (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy);
      md_op = op; A = a; B = b; cancel = 1'b0;
      step();
      md_op = 4'd0;
      nbusy = 0;
      while (busy === 1'b1 && nbusy < 40) begin
         nbusy++;
         step();
      end
   endtask

   task automatic test_reset();
      md_op = 0; A = 0; B = 0; cancel = 0; reset = 1'b1;
      step(); step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
      checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall); end
      reset = 1'b0;
      step();
      m_hi = 0; m_lo = 0;
   endtask

   task automatic test_mult();
      int n;
      md_op = 4'd1; A = 32'hFFFFFFFF; B = 32'd2; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mult_issue_stall got %0h exp 1", stall); end
      run_op(4'd1, 32'hFFFFFFFF, 32'd2, n);
      checks++; if (n !== NM) begin errors++; $display("FAIL mult_busy_cycles got %0d exp %0d", n, NM); end
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_res got %h/%h exp ffffffff/fffffffe", hi, lo); end
      run_op(4'd2, 32'hFFFFFFFF, 32'd2, n);
      checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_res got %h/%h exp 00000001/fffffffe", hi, lo); end
   endtask

   task automatic test_div();
      int n;
      run_op(4'd3, -32'sd7, 32'd2, n);
      checks++; if (n !== ND) begin errors++; $display("FAIL div_busy_cycles got %0d exp %0d", n, ND); end
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_res got %h/%h exp ffffffff/fffffffd", hi, lo); end
      run_op(4'd4, 32'd7, 32'd0, n);
      checks++; if (hi !== 32'd7 || lo !== 32'hFFFFFFFF || n !== ND) begin errors++; $display("FAIL divu_zero got %h/%h n=%0d exp 00000007/ffffffff n=%0d", hi, lo, n, ND); end
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
      checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h/%h exp 00000000/80000000", hi, lo); end
   endtask

   task automatic test_mthi_busy();
      int n;
      md_op = 4'd1; A = 32'd5; B = 32'd6; cancel = 0;
      step();
      md_op = 4'd5; A = 32'h1234;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         checks++; if (stall !== 1'b1 || hi !== 32'h0) begin errors++; $display("FAIL mthi_hold got stall=%0h hi=%h exp stall=1 hi=00000000", stall, hi); end
         n++;
         step();
      end
      checks++; if (hi !== 32'd0 || lo !== 32'd30 || n !== NM) begin errors++; $display("FAIL mthi_after_run got %h/%h n=%0d exp 00000000/0000001e n=%0d", hi, lo, n, NM); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_idle_stall got %0h exp 0", stall); end
      step();
      md_op = 4'd7; #1;
      checks++; if (hi !== 32'h1234 || md_rd !== 32'h1234) begin errors++; $display("FAIL mthi_apply got hi=%h rd=%h exp 00001234", hi, md_rd); end
      md_op = 4'd0;
   endtask

   task automatic test_cancel();
      int n;
      logic [31:0] h0, l0;
      h0 = 32'h1234; l0 = 32'd30;
      md_op = 4'd1; A = 32'd3; B = 32'd3; cancel = 1'b1;
      step();
      md_op = 0; cancel = 0;
      checks++; if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin errors++; $display("FAIL cancel_start got busy=%0h %h/%h exp 0 %h/%h", busy, hi, lo, h0, l0); end
      md_op = 4'd6; A = 32'hDEAD; cancel = 1'b1;
      step();
      md_op = 0; cancel = 0;
      checks++; if (lo !== l0) begin errors++; $display("FAIL cancel_mtlo got %h exp %h", lo, l0); end
      md_op = 4'd1; A = 32'd3; B = 32'd3;
      step();
      md_op = 0;
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      n = 2;
      while (busy === 1'b1 && n < 40) begin n++; step(); end
      checks++; if (lo !== 32'd9 || hi !== 32'd0 || n !== NM) begin errors++; $display("FAIL cancel_in_run got %h/%h n=%0d exp 00000000/00000009 n=%0d", hi, lo, n, NM); end
   endtask

   task automatic test_reset_mid();
      md_op = 4'd5; A = 32'hAAAA5555; step();
      md_op = 4'd3; A = 32'd100; B = 32'd7; step();
      md_op = 4'd0; step(); step();
      reset = 1'b1; #1;
      checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid got busy=%0h %h/%h exp 0 0/0", busy, hi, lo); end
      step();
      reset = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || hi !== 32'd0) begin errors++; $display("FAIL reset_mid_after got busy=%0h hi=%h exp 0 0", busy, hi); end
      m_hi = 0; m_lo = 0;
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      logic        c;
      logic [63:0] exp;
      int n;
      for (int it = 0; it < 60; it++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 9));
         c  = ($urandom_range(0, 7) == 0);
         md_op = op; A = a; B = b; cancel = c; #1;
         checks++; if (stall !== model_start(op)) begin errors++; $display("FAIL rnd_stall it=%0d op=%0d got %0h exp %0h", it, op, stall, model_start(op)); end
         if (op == 7 || op == 8) begin
            checks++; if (md_rd !== ((op == 7) ? m_hi : m_lo)) begin errors++; $display("FAIL rnd_mf it=%0d got %h exp %h", it, md_rd, (op == 7) ? m_hi : m_lo); end
         end
         step();
         md_op = 0; cancel = 0;
         if (model_start(op) && !c) begin
            exp = model_res(op, a, b, {m_hi, m_lo});
            n = 0;
            while (busy === 1'b1 && n < 40) begin n++; step(); end
            m_hi = exp[63:32]; m_lo = exp[31:0];
            checks++; if (n !== model_lat(op)) begin errors++; $display("FAIL rnd_lat it=%0d op=%0d got %0d exp %0d", it, op, n, model_lat(op)); end
         end else begin
            if (!c && op == 5) m_hi = a;
            if (!c && op == 6) m_lo = a;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_nobusy it=%0d op=%0d got %0h exp 0", it, op, busy); end
         end
         checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rnd_hilo it=%0d op=%0d a=%h b=%h got %h/%h exp %h/%h", it, op, a, b, hi, lo, m_hi, m_lo); end
      end
   endtask

   initial begin
      reset = 1'b1; md_op = 0; A = 0; B = 0; cancel = 0;
      test_reset();
      test_mult();
      test_div();
      test_mthi_busy();
      test_cancel();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
